load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store sequencer that drives the word-addressed data memory port (`MemRead`/`MemWrite`/`address`/`writedata`/`readdata`) on behalf of the pipeline's MEM stage. It accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests through a ready/valid handshake and performs lane extraction with sign or zero extension. Sub-word stores use read-modify-write, because the memory has no byte enables. The unit also range-checks and alignment-checks every request and reports faults without touching memory.

## Interface
- `MEM_WORDS`, default 256: number of 32-bit words in the data memory. A word index `>= MEM_WORDS` is out of range.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: pipeline request strobe.
- `req_ready` output 1: high only in IDLE; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_op` input 4: `{store, unsigned, size[1:0]}`.
  - size: 00 = byte, 01 = half, 10 = word, 11 = reserved (fault).
  - `unsigned` is ignored for stores and for word loads.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; the byte or half is taken from the low bits.
- `resp_valid` output 1: one-cycle pulse when the access completes.
- `resp_rdata` output 32: extended load data; 0 for stores and faults; held until the next `resp_valid`.
- `resp_err` output 1: valid with `resp_valid`; 1 indicates a fault.
- `MemRead` output 1, `MemWrite` output 1: memory strobes.
- `address` output 32: word index `{2'b00, addr[31:2]}`.
- `writedata` output 32: memory write data.
- `readdata` input 32: memory read data, combinational from `address`/`MemRead`.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE, on accept: latch op, addr, wdata, then evaluate faults.
  - Fault conditions: reserved size; word index `>= MEM_WORDS`; misalignment (half with `addr[0]=1`, word with `addr[1:0]!=0`).
  - Fault → RESP with `resp_err=1`; no strobe is ever raised.
  - Load, SB or SH → RD. SW → WR.
- RD: `MemRead=1`, `address` = word index. Capture `readdata` into the word buffer at the edge.
  - Load → RESP.
  - SB/SH → WR.
- WR: `MemWrite=1`, then → RESP.
  - SW writes `req_wdata`.
  - SB/SH write the buffered word with only the target lane replaced.
- RESP: `resp_valid=1`, then → IDLE.
- Lane rules are little-endian.
  - Byte lane `n = addr[1:0]` occupies bits `[8n+7:8n]`.
  - Half lane `h = addr[1]` occupies bits `[16h+15:16h]`.
  - Loads sign-extend, or zero-extend when `unsigned=1`.
- `MemRead` and `MemWrite` are never high in the same cycle and are 0 in IDLE and RESP. `address`/`writedata` are 0 when no strobe is active.
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `MemRead=0`, `MemWrite=0`, `address=0`, `writedata=0`, buffers 0.
- Reset mid-operation:
  - All strobes drop immediately (asynchronously) and the transaction is discarded with no response.
  - If reset asserts in RD of an SB/SH, the memory is unmodified.

## Timing
- Cycle 0 is the accept edge; the state is entered after that edge.
- LW/LH/LB: RD in cycle 1, `resp_valid` in cycle 2. Latency 2, one request per 3 cycles.
- SW: WR in cycle 1, `resp_valid` in cycle 2.
- SB/SH: RD in cycle 1, WR in cycle 2, `resp_valid` in cycle 3.
- Fault: `resp_valid` in cycle 1 with `resp_err=1`.
- `req_valid` while `req_ready=0` is ignored; the requester must hold it until accepted.
- Strobes are Moore outputs of the state register, with no combinational path from `req_*`.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: misaligned half/word requests fault as described above.
- Not defined:
  - No misalignment fault.
  - Half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.
  - The access proceeds on the aligned lane.
  - Reserved-size and range faults remain.

## Test plan
- Reset, then SW `addr=0x10`, `wdata=0xDEADBEEF` → WR in cycle 1 with `address=4`, `writedata=0xDEADBEEF`; `resp_valid` in cycle 2 with `resp_err=0`. Then LW `0x10` → `resp_rdata=0xDEADBEEF` in cycle 2.
- With word 4 = `0xDEADBEEF`: LB `0x13` → `0xFFFFFFDE`; LBU `0x13` → `0x000000DE`; LH `0x10` → `0xFFFFBEEF`; LHU `0x12` → `0x0000DEAD`.
- With word 4 = `0xDEADBEEF`:
  - SB `0x11`, `wdata=0x12` → RD cycle 1, WR cycle 2 with `writedata=0xDEAD12EF`, `resp_valid` cycle 3.
  - SH `0x12`, `wdata=0xCAFE` → `0xCAFE12EF`.
- LW `addr=0x400` with `MEM_WORDS=256` → `resp_err=1` in cycle 1; `MemRead`/`MemWrite` stay 0 throughout. LH `0x11` → `resp_err=1` with the macro defined. Without the macro, LH `0x11` reads lane 0 with `resp_err=0`.
- SB accepted, `rst_n` pulsed low during RD → strobes drop in the same cycle, memory word unchanged, no `resp_valid`, and `req_ready=1` after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer for a word-addressed data memory without byte enables.
// Sub-word stores use read-modify-write. Define LSU_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] address,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_fault, misalign, out_range;
    logic [31:0] byte_sh, half_sh, load_ext, merged;

    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        misalign = (req_op[1:0] == 2'b01 && req_addr[0]) ||
                   (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        out_range = {2'b00, req_addr[31:2]} >= MEM_LIMIT;
        req_fault = (req_op[1:0] == 2'b11) || out_range || misalign;
    end

    // Lane extraction: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        byte_sh = readdata >> {addr_q[1:0], 3'b000};
        half_sh = readdata >> {addr_q[1], 4'b0000};
        case (op_q[1:0])
            2'b00:   load_ext = op_q[2] ? {24'h0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_ext = op_q[2] ? {16'h0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
            default: load_ext = readdata;
        endcase
    end

    always_comb begin
        merged = buf_q;
        case (op_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                op_d    = req_op;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                if (req_fault) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = S_RESP;
                end else if (req_op[3] && req_op[1:0] == 2'b10) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                buf_d = readdata;
                if (op_q[3]) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = load_ext;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            buf_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes decode only the state register, so reset drops them at once.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign MemRead    = (state_q == S_RD);
    assign MemWrite   = (state_q == S_WR);
    assign address    = (MemRead || MemWrite) ? {2'b00, addr_q[31:2]} : 32'h0;
    assign writedata  = MemWrite ? merged : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word-array reference model predicts every cycle of each access.
module tb_load_store_unit;
    localparam int MW = 256;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead, MemWrite;
    logic [31:0] address, writedata, readdata;

    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [31:0] hold = 32'h0;

    typedef struct {
        logic        ready, rd, wr;
        logic [31:0] addr, wd;
        logic        rv, err;
        logic [31:0] rdata;
    } rec_t;
    rec_t q[$];
    rec_t e;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
        .writedata(writedata), .readdata(readdata)
    );

    always #5 clk = ~clk;

    assign readdata = (MemRead && address < 32'(MW)) ? mem[address[7:0]] : 32'h0;
    always @(posedge clk) if (MemWrite && address < 32'(MW)) mem[address[7:0]] <= writedata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(logic ready, logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
                                logic rv, logic err, logic [31:0] rdata);
        rec_t r;
        r.ready = ready; r.rd = rd; r.wr = wr; r.addr = a; r.wd = wd;
        r.rv = rv; r.err = err; r.rdata = rdata;
        return r;
    endfunction

    // Per-cycle compare against the queued expectations; an empty queue means idle.
    always @(negedge clk) if (chk_en) begin
        if (q.size() > 0) e = q.pop_front();
        else e = mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("req_ready", {31'h0, req_ready}, {31'h0, e.ready});
        chk("MemRead", {31'h0, MemRead}, {31'h0, e.rd});
        chk("MemWrite", {31'h0, MemWrite}, {31'h0, e.wr});
        chk("address", address, e.addr);
        chk("writedata", writedata, e.wd);
        chk("resp_valid", {31'h0, resp_valid}, {31'h0, e.rv});
        if (e.rv) begin
            chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
            hold = e.rdata;
        end
        chk("resp_rdata", resp_rdata, hold);
    end

    // Reference behaviour from byte-address rules on a plain word array.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic flt, output logic [31:0] rd, output logic [31:0] nw);
        logic [31:0] w;
        int sh;
        flt = (op[1:0] == 2'b11) || (int'(a[31:2]) >= MW) ||
              (ALIGN && ((op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b10 && a[1:0] != 2'b00)));
        w = flt ? 32'h0 : ref_mem[a[9:2]];
        rd = 32'h0;
        nw = w;
        if (!flt) begin
            if (op[1:0] == 2'b00) begin
                sh = 8 * int'(a[1:0]);
                if (op[3]) nw = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                else begin
                    rd = (w >> sh) & 32'hFF;
                    if (!op[2] && rd[7]) rd = rd | 32'hFFFF_FF00;
                end
            end else if (op[1:0] == 2'b01) begin
                sh = 16 * int'(a[1]);
                if (op[3]) nw = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                else begin
                    rd = (w >> sh) & 32'hFFFF;
                    if (!op[2] && rd[15]) rd = rd | 32'hFFFF_0000;
                end
            end else begin
                if (op[3]) nw = wd;
                else rd = w;
            end
        end
    endtask

    // Issue one request at posedge+1 and return at posedge+1 once the unit is idle again.
    task automatic do_req(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] lit);
        logic flt;
        logic [31:0] rd, nw, idx;
        int k;
        model(op, a, wd, flt, rd, nw);
        idx = {2'b00, a[31:2]};
        chk({nm, "_model"}, (op[3] && !flt) ? nw : rd, lit);
        q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
        if (flt) begin
            k = 1;
        end else if (!op[3]) begin
            k = 2;
            q.push_back(mk(1'b0, 1'b1, 1'b0, idx, 32'h0, 1'b0, 1'b0, 32'h0));
        end else if (op[1:0] == 2'b10) begin
            k = 2;
            q.push_back(mk(1'b0, 1'b0, 1'b1, idx, nw, 1'b0, 1'b0, 32'h0));
        end else begin
            k = 3;
            q.push_back(mk(1'b0, 1'b1, 1'b0, idx, 32'h0, 1'b0, 1'b0, 32'h0));
            q.push_back(mk(1'b0, 1'b0, 1'b1, idx, nw, 1'b0, 1'b0, 32'h0));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, flt, rd));
        if (op[3] && !flt) ref_mem[a[9:2]] = nw;
        req_op = op; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        if (int'(a[31:2]) < MW) chk({nm, "_mem"}, mem[a[9:2]], ref_mem[a[9:2]]);
    endtask

    initial begin
        for (int i = 0; i < MW; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        #2;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        chk("rst_address", address, 32'h0);
        chk("rst_writedata", writedata, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        do_req("sw10",  4'b1010, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF);
        do_req("lw10",  4'b0010, 32'h10,  32'h0,        32'hDEADBEEF);
        do_req("lb13",  4'b0000, 32'h13,  32'h0,        32'hFFFFFFDE);
        do_req("lbu13", 4'b0100, 32'h13,  32'h0,        32'h000000DE);
        do_req("lh10",  4'b0001, 32'h10,  32'h0,        32'hFFFFBEEF);
        do_req("lhu12", 4'b0101, 32'h12,  32'h0,        32'h0000DEAD);
        do_req("sb11",  4'b1000, 32'h11,  32'h12,       32'hDEAD12EF);
        do_req("sh12",  4'b1001, 32'h12,  32'hCAFE,     32'hCAFE12EF);
        do_req("lw400", 4'b0010, 32'h400, 32'h0,        32'h0);
        do_req("sb400", 4'b1000, 32'h400, 32'hFF,       32'h0);
        do_req("rsvd",  4'b0011, 32'h10,  32'h0,        32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        do_req("lh11",  4'b0001, 32'h11,  32'h0,        32'h0);
        do_req("lw12",  4'b0010, 32'h12,  32'h0,        32'h0);
`else
        do_req("lh11",  4'b0001, 32'h11,  32'h0,        32'h000012EF);
        do_req("lw12",  4'b0010, 32'h12,  32'h0,        32'hCAFE12EF);
`endif
        do_req("sw3fc", 4'b1010, 32'h3FC, 32'h80017F00, 32'h80017F00);
        do_req("lb3fd", 4'b0000, 32'h3FD, 32'h0,        32'h0000007F);
        do_req("lh3fe", 4'b0001, 32'h3FE, 32'h0,        32'hFFFF8001);
        do_req("sb3fc", 4'b1000, 32'h3FC, 32'hA5A5A5A5, 32'h80017FA5);

        // Reset pulsed while an SB sits in RD: strobes drop at once, no write, no response.
        chk_en = 1'b0;
        req_op = 4'b1000; req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_rd_active", {31'h0, MemRead}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        chk("mid_rst_address", address, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
            chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
        end
        chk("post_rst_mem", mem[4], 32'hCAFE12EF);
        @(posedge clk); #1;
        hold = 32'h0;
        chk_en = 1'b1;
        do_req("lw10b", 4'b0010, 32'h10, 32'h0, 32'hCAFE12EF);
        do_req("lbu12", 4'b0100, 32'h12, 32'h0, 32'h000000FE);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
